// File: rtl/dac_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_channel_arbiter_if
//  Description : Requester-side bus of the DAC channel arbiter. Carries the
//                per-channel req/sample inputs and the ack/grant_id/busy
//                status back to the voices.
//  Revision    : 1.0  initial release
// ============================================================================
interface dac_channel_arbiter_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 8
);
  logic [NCH-1:0]        req;
  logic [NCH*DATA_W-1:0] sample;
  logic [NCH-1:0]        ack;
  logic [1:0]            grant_id;
  logic                  busy;

  // Voice/mixer side
  modport master (output req, sample, input ack, grant_id, busy);
  // Arbiter side
  modport slave  (input req, sample, output ack, grant_id, busy);
endinterface
`default_nettype wire

// File: rtl/dac_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dac_channel_arbiter
//  Description : Round-robin arbiter sharing one serial DAC between up to four
//                requesters. Each grant sends an 11-bit word (A1 A0 RNG D7..D0,
//                MSB first) followed by the load and ldac strobes.
//                Optional build macro DAC_SIMUL_UPDATE_EN: ldac is pulsed only
//                after the word of channel NCH-1, so all channel outputs update
//                together once per round.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_channel_arbiter #(
  parameter int   NCH      = 4,
  parameter int   DATA_W   = 8,
  parameter int   CLK_DIV  = 20,
  parameter int   LOAD_CYC = 40,
  parameter int   LDAC_CYC = 40,
  parameter logic RNG      = 1'b0
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  dac_channel_arbiter_if.slave bus,
  output logic                 dclk,
  output logic                 data,
  output logic                 load,
  output logic                 ldac
);

  // Serial word: two address bits, the RNG bit, then the sample
  localparam int c_word_w  = DATA_W + 3;
  localparam int c_bit_w   = $clog2(c_word_w);
  localparam int c_cnt_max = (CLK_DIV > LOAD_CYC) ?
                             ((CLK_DIV > LDAC_CYC) ? CLK_DIV : LDAC_CYC) :
                             ((LOAD_CYC > LDAC_CYC) ? LOAD_CYC : LDAC_CYC);
  localparam int c_cnt_w   = $clog2(c_cnt_max);

  localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_load_last = c_cnt_w'(LOAD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_ldac_last = c_cnt_w'(LDAC_CYC - 1);
  localparam logic [c_bit_w-1:0] c_bit_first = c_bit_w'(c_word_w - 1);
  localparam logic [NCH-1:0]     c_one       = NCH'(1);
  localparam logic [1:0]         c_last_ch   = 2'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_LDAC  = 2'd3
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt,    w_cnt_nxt;
  logic [c_bit_w-1:0]    r_bit,    w_bit_nxt;
  logic [c_word_w-1:0]   r_shreg,  w_shreg_nxt;
  logic                  r_dclk,   w_dclk_nxt;
  logic                  r_data,   w_data_nxt;
  logic                  r_load,   w_load_nxt;
  logic                  r_ldac,   w_ldac_nxt;
  logic [NCH-1:0]        r_ack,    w_ack_nxt;
  logic                  r_busy,   w_busy_nxt;
  logic [1:0]            r_grant,  w_grant_nxt;
  logic [1:0]            r_rr_ptr, w_rr_nxt;

  logic [NCH-1:0]        w_req;
  logic                  w_found;
  logic [1:0]            w_gnt;
  logic [DATA_W-1:0]     w_sample;
  int                    w_idx;

  assign w_req = bus.req;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NCH;
      if (!w_found && (|(w_req & (c_one << w_idx)))) begin
        w_found = 1'b1;
        w_gnt   = 2'(w_idx);
      end
    end
  end

  // Sample of the channel that would be granted this cycle
  assign w_sample = DATA_W'(bus.sample >> (int'(w_gnt) * DATA_W));

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_dclk   <= 1'b0;
      r_data   <= 1'b0;
      r_load   <= 1'b1;
      r_ldac   <= 1'b1;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_grant  <= '0;
      r_rr_ptr <= c_last_ch;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shreg  <= w_shreg_nxt;
      r_dclk   <= w_dclk_nxt;
      r_data   <= w_data_nxt;
      r_load   <= w_load_nxt;
      r_ldac   <= w_ldac_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Frame sequencing: grant, serialise, load strobe, ldac strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_dclk_nxt  = r_dclk;
    w_data_nxt  = r_data;
    w_load_nxt  = r_load;
    w_ldac_nxt  = r_ldac;
    w_ack_nxt   = '0;
    w_busy_nxt  = r_busy;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ack_nxt   = c_one << w_gnt;
          w_shreg_nxt = {w_gnt, RNG, w_sample};
          w_grant_nxt = w_gnt;
          w_rr_nxt    = w_gnt;
          w_busy_nxt  = 1'b1;
          w_dclk_nxt  = 1'b1;
          w_data_nxt  = w_gnt[1];
          w_cnt_nxt   = '0;
          w_bit_nxt   = c_bit_first;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (r_cnt == c_div_last) begin
          w_cnt_nxt = '0;
          if (r_dclk) begin
            // End of high phase; the DAC samples on this falling edge
            w_dclk_nxt = 1'b0;
          end else if (r_bit == '0) begin
            w_data_nxt  = 1'b0;
            w_load_nxt  = 1'b0;
            w_state_nxt = S_LOAD;
          end else begin
            // Next bit is presented together with the rising dclk edge
            w_dclk_nxt  = 1'b1;
            w_bit_nxt   = r_bit - 1'b1;
            w_shreg_nxt = r_shreg << 1;
            w_data_nxt  = r_shreg[c_word_w-2];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_LOAD: begin
        if (r_cnt == c_load_last) begin
          w_cnt_nxt  = '0;
          w_load_nxt = 1'b1;
`ifdef DAC_SIMUL_UPDATE_EN
          if (r_grant == c_last_ch) begin
            w_ldac_nxt  = 1'b0;
            w_state_nxt = S_LDAC;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
`else
          w_ldac_nxt  = 1'b0;
          w_state_nxt = S_LDAC;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_LDAC: begin
        if (r_cnt == c_ldac_last) begin
          w_cnt_nxt   = '0;
          w_ldac_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ack      = r_ack;
  assign bus.grant_id = r_grant;
  assign bus.busy     = r_busy;
  assign dclk         = r_dclk;
  assign data         = r_data;
  assign load         = r_load;
  assign ldac         = r_ldac;

endmodule
`default_nettype wire
